// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - mispredict flush/redirect control with committed-path return address stack
module branch_redirect_ctrl #(
  parameter int XLEN      = 64,
  parameter int ROB_TAG_W = 6,
  parameter int RAS_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 br_valid,
  input  logic [XLEN-1:0]      br_pc,
  input  logic                 br_taken,
  input  logic [XLEN-1:0]      br_target_pc,
  input  logic                 br_mispredict,
  input  logic                 br_is_call,
  input  logic                 br_is_return,
  input  logic [ROB_TAG_W-1:0] br_rob_tag,
  input  logic [ROB_TAG_W-1:0] rob_head,
  input  logic                 redirect_ready,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 flush_valid,
  output logic [ROB_TAG_W-1:0] flush_rob_tag,
  output logic [XLEN-1:0]      ras_top,
  output logic                 ras_valid,
  output logic [31:0]          mispredict_count
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0] RAS_FULL = RAS_DEPTH[PTR_W:0];

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FLUSH    = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  logic [1:0]           state;
  logic [ROB_TAG_W-1:0] pend_tag;
  logic [XLEN-1:0]      pend_pc;

  logic [XLEN-1:0]      ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]     ras_ptr;
  logic [PTR_W:0]       ras_count;

  logic [ROB_TAG_W-1:0] age_new;
  logic [ROB_TAG_W-1:0] age_pend;
  logic                 accept;
  logic                 take_mp;
  logic [XLEN-1:0]      correct_pc;
  logic [XLEN-1:0]      link_pc;

  // Age is distance from the ROB head; while a redirect is pending only strictly older beats are on the correct path
  assign age_new    = br_rob_tag - rob_head;
  assign age_pend   = pend_tag - rob_head;
  assign accept     = br_valid && ((state == IDLE) || (age_new < age_pend));
  assign take_mp    = accept && br_mispredict;
  assign link_pc    = br_pc + XLEN'(4);
  assign correct_pc = br_taken ? br_target_pc : link_pc;

  // Redirect FSM: a newly accepted mispredict always restarts at FLUSH, even over a same-cycle handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pend_tag <= '0;
      pend_pc  <= '0;
    end else if (take_mp) begin
      state    <= FLUSH;
      pend_tag <= br_rob_tag;
      pend_pc  <= correct_pc;
    end else begin
      case (state)
        FLUSH:    state <= redirect_ready ? IDLE : REDIRECT;
        REDIRECT: state <= redirect_ready ? IDLE : REDIRECT;
        default:  state <= IDLE;
      endcase
    end
  end

  // Saturating count of accepted mispredicts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_count <= '0;
    end else if (take_mp && (mispredict_count != 32'hFFFF_FFFF)) begin
      mispredict_count <= mispredict_count + 32'd1;
    end
  end

  // Circular RAS: push writes above the top pointer, so a full stack overwrites its oldest entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (accept && br_is_call) begin
      ras_mem[ras_ptr + PTR_W'(1)] <= link_pc;
      ras_ptr                      <= ras_ptr + PTR_W'(1);
      if (ras_count != RAS_FULL) begin
        ras_count <= ras_count + (PTR_W+1)'(1);
      end
    end else if (accept && br_is_return && (ras_count != '0)) begin
      ras_ptr   <= ras_ptr - PTR_W'(1);
      ras_count <= ras_count - (PTR_W+1)'(1);
    end
  end

  assign flush_valid    = (state == FLUSH);
  assign flush_rob_tag  = flush_valid ? pend_tag : '0;
  assign redirect_valid = (state != IDLE);
  assign redirect_pc    = redirect_valid ? pend_pc : '0;
  assign ras_valid      = (ras_count != '0);
  assign ras_top        = ras_valid ? ras_mem[ras_ptr] : '0;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - directed scoreboard bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [63:0] br_pc;
  logic        br_taken;
  logic [63:0] br_target_pc;
  logic        br_mispredict;
  logic        br_is_call;
  logic        br_is_return;
  logic [5:0]  br_rob_tag;
  logic [5:0]  rob_head;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush_valid;
  logic [5:0]  flush_rob_tag;
  logic [63:0] ras_top;
  logic        ras_valid;
  logic [31:0] mispredict_count;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic        rv;
    logic [63:0] rpc;
    logic        fv;
    logic [5:0]  ftag;
    logic        rasv;
    logic [63:0] rast;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  branch_redirect_ctrl #(.XLEN(64), .ROB_TAG_W(6), .RAS_DEPTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .br_valid         (br_valid),
    .br_pc            (br_pc),
    .br_taken         (br_taken),
    .br_target_pc     (br_target_pc),
    .br_mispredict    (br_mispredict),
    .br_is_call       (br_is_call),
    .br_is_return     (br_is_return),
    .br_rob_tag       (br_rob_tag),
    .rob_head         (rob_head),
    .redirect_ready   (redirect_ready),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush_valid      (flush_valid),
    .flush_rob_tag    (flush_rob_tag),
    .ras_top          (ras_top),
    .ras_valid        (ras_valid),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic rv, input logic [63:0] rpc,
                            input logic fv, input logic [5:0] ftag, input logic rasv,
                            input logic [63:0] rast, input logic [31:0] cnt);
    exp_t e;
    e.rv = rv; e.rpc = rpc; e.fv = fv; e.ftag = ftag;
    e.rasv = rasv; e.rast = rast; e.cnt = cnt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check();
    exp_t  e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp({t, ".redirect_valid"},   {63'd0, redirect_valid}, {63'd0, e.rv});
      cmp({t, ".redirect_pc"},      redirect_pc, e.rpc);
      cmp({t, ".flush_valid"},      {63'd0, flush_valid}, {63'd0, e.fv});
      cmp({t, ".flush_rob_tag"},    {58'd0, flush_rob_tag}, {58'd0, e.ftag});
      cmp({t, ".ras_valid"},        {63'd0, ras_valid}, {63'd0, e.rasv});
      cmp({t, ".ras_top"},          ras_top, e.rast);
      cmp({t, ".mispredict_count"}, {32'd0, mispredict_count}, {32'd0, e.cnt});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic tk,
                       input logic [63:0] tgt, input logic mp, input logic call,
                       input logic ret, input logic [5:0] tag);
    br_valid = v; br_pc = pc; br_taken = tk; br_target_pc = tgt;
    br_mispredict = mp; br_is_call = call; br_is_return = ret; br_rob_tag = tag;
  endtask

  task automatic idle_bus();
    drive(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  initial begin
    reset = 1'b1;
    rob_head = 6'd0;
    redirect_ready = 1'b0;
    idle_bus();
    #12;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
    check();
    tick();
    reset = 1'b0;
    #1;

    // taken mispredict with immediate ready
    redirect_ready = 1'b1;
    drive(1, 64'h50, 1, 64'h1000, 1, 0, 0, 6'd5);
    expect_out("mp_taken_flush", 1, 64'h1000, 1, 6'd5, 0, 0, 1);
    tick();
    idle_bus();
    expect_out("mp_taken_idle", 0, 0, 0, 0, 0, 0, 1);
    tick();

    // not-taken mispredict, fetch stalls three cycles
    redirect_ready = 1'b0;
    drive(1, 64'h200, 0, 64'h9999, 1, 0, 0, 6'd7);
    expect_out("nt_flush", 1, 64'h204, 1, 6'd7, 0, 0, 2);
    tick();
    idle_bus();
    expect_out("nt_hold1", 1, 64'h204, 0, 0, 0, 0, 2);
    tick();
    expect_out("nt_hold2", 1, 64'h204, 0, 0, 0, 0, 2);
    tick();
    expect_out("nt_hold3", 1, 64'h204, 0, 0, 0, 0, 2);
    tick();
    redirect_ready = 1'b1;
    expect_out("nt_done", 0, 0, 0, 0, 0, 0, 2);
    tick();

    // age compare across tag wrap
    rob_head = 6'd60;
    redirect_ready = 1'b0;
    drive(1, 64'h300, 1, 64'h3000, 1, 0, 0, 6'd62);
    expect_out("age_flush62", 1, 64'h3000, 1, 6'd62, 0, 0, 3);
    tick();
    idle_bus();
    expect_out("age_redir62", 1, 64'h3000, 0, 0, 0, 0, 3);
    tick();
    drive(1, 64'h400, 1, 64'h4000, 1, 0, 0, 6'd1);
    expect_out("age_young_drop", 1, 64'h3000, 0, 0, 0, 0, 3);
    tick();
    drive(1, 64'h500, 1, 64'h5000, 1, 0, 0, 6'd61);
    expect_out("age_older_flush", 1, 64'h5000, 1, 6'd61, 0, 0, 4);
    tick();
    idle_bus();
    expect_out("age_redir61", 1, 64'h5000, 0, 0, 0, 0, 4);
    tick();
    drive(1, 64'h9000, 0, 64'h0, 0, 1, 0, 6'd63);
    expect_out("wrongpath_call", 1, 64'h5000, 0, 0, 0, 0, 4);
    tick();
    // older mispredict beats same-cycle handshake
    redirect_ready = 1'b1;
    drive(1, 64'h600, 1, 64'h6000, 1, 0, 0, 6'd60);
    expect_out("older_over_ready", 1, 64'h6000, 1, 6'd60, 0, 0, 5);
    tick();
    idle_bus();
    expect_out("age_done", 0, 0, 0, 0, 0, 0, 5);
    tick();

    // RAS overflow then underflow
    for (int i = 0; i < 9; i++) begin
      drive(1, 64'h100 * i, 1, 64'h8000, 0, 1, 0, 6'(i));
      expect_out($sformatf("ras_call%0d", i), 0, 0, 0, 0, 1, 64'h100 * i + 64'h4, 5);
      tick();
    end
    for (int k = 1; k <= 9; k++) begin
      drive(1, 64'h7000, 1, 64'h8000, 0, 0, 1, 6'(k));
      if (k <= 7)
        expect_out($sformatf("ras_ret%0d", k), 0, 0, 0, 0, 1, 64'h100 * (8 - k) + 64'h4, 5);
      else
        expect_out($sformatf("ras_ret%0d", k), 0, 0, 0, 0, 0, 0, 5);
      tick();
    end
    idle_bus();

    // reset in the middle of a redirect
    redirect_ready = 1'b0;
    drive(1, 64'h700, 1, 64'h6000, 1, 0, 0, 6'd10);
    expect_out("rst_flush", 1, 64'h6000, 1, 6'd10, 0, 0, 6);
    tick();
    idle_bus();
    expect_out("rst_redir", 1, 64'h6000, 0, 0, 0, 0, 6);
    tick();
    reset = 1'b1;
    #1;
    expect_out("rst_async", 0, 0, 0, 0, 0, 0, 0);
    check();
    tick();
    reset = 1'b0;
    expect_out("rst_after1", 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_out("rst_after2", 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
